mult_div_unit: RTL and testbench

//  Iterative MIPS multiply/divide unit owning the HI/LO registers. Executes

---
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring divide,
// one step per cycle, with a final sign-fix cycle before HI/LO are written.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic             hi_lo_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] data_out_o
);

  // state  | meaning
  // S_IDLE | waiting for start; accepts mthi/mtlo
  // S_CALC | one multiply or divide step per cycle, WIDTH steps
  // S_SIGN | apply sign fix, write HI/LO, pulse done
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_e;

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, neg_res_q, neg_rem_q, done_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q, hi_q, lo_q;

  logic             op_signed;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  logic [WIDTH:0]   add_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CALC;
      S_CALC:  if (cnt_q == CW'(WIDTH-1)) state_d = S_SIGN;
      S_SIGN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != S_IDLE);
    done_o     = done_q;
    hi_o       = hi_q;
    lo_o       = lo_q;
    data_out_o = hi_lo_sel_i ? hi_q : lo_q;
  end

  always_comb begin
    op_signed = ~op_i[0];
    rs_abs    = (op_signed && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
    rt_abs    = (op_signed && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;

    add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];

    prod_fix  = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    // Divide by zero leaves the dividend magnitude in the remainder, so the
    // remainder sign fix restores rs exactly; the quotient stays all ones.
    if (is_div_q) begin
      res_lo = (opb_q == '0) ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
      res_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end else begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            is_div_q  <= op_i[1];
            neg_res_q <= op_signed & (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
            neg_rem_q <= op_signed & rs_data_i[WIDTH-1];
            acc_hi_q  <= '0;
            acc_lo_q  <= rs_abs;
            opb_q     <= rt_abs;
            cnt_q     <= '0;
          end else begin
            if (mthi_i) hi_q <= rs_data_i;
            if (mtlo_i) lo_q <= rs_data_i;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            acc_hi_q <= div_rem;
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_hi_q <= add_sum[WIDTH:1];
            acc_lo_q <= {add_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        S_SIGN: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  rs = '0, rt = '0;
  logic          mthi = 1'b0, mtlo = 1'b0, sel = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi, lo, dout;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .rs_data_i(rs), .rt_data_i(rt), .mthi_i(mthi), .mtlo_i(mtlo),
    .hi_lo_sel_i(sel), .busy_o(busy), .done_o(done),
    .hi_o(hi), .lo_o(lo), .data_out_o(dout)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] mop, input logic [31:0] a, b,
                                output logic [31:0] mh, output logic [31:0] ml);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    case (mop)
      2'd0: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
      2'd1: begin u = {32'd0, a} * {32'd0, b}; mh = u[63:32]; ml = u[31:0]; end
      2'd2: begin
        if (b == 0) begin mh = a; ml = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; mh = r[31:0]; ml = q[31:0]; end
      end
      default: begin
        if (b == 0) begin mh = a; ml = 32'hFFFF_FFFF; end
        else begin mh = a % b; ml = a / b; end
      end
    endcase
  endfunction

  // Launch an op and observe a fixed 36-cycle window after the start edge.
  // noise scrambles operands and pokes start/mthi/mtlo while busy.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, b, input bit noise,
                       output int busy_cnt, output int done_cnt, output int done_at,
                       output int overlap);
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0; overlap = 0;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_at == 0) done_at = i; end
      if (busy && done) overlap++;
      if (noise) begin
        rs = $urandom; rt = $urandom;
        start = (i == 10); mthi = (i == 12); mtlo = (i == 14);
        op = 2'($urandom_range(0, 3));
      end
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a, b,
                          input bit noise);
    int bc, dc, da, ov;
    logic [31:0] eh, el;
    model(o, a, b, eh, el);
    do_op(o, a, b, noise, bc, dc, da, ov);
    checks++; if (bc !== 33) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=33", name, bc); end
    checks++; if (da !== 34 || dc !== 1) begin failures++; $display("FAIL %s done_pulse at=%0d count=%0d exp at=34 count=1", name, da, dc); end
    checks++; if (ov !== 0) begin failures++; $display("FAIL %s busy_done_overlap got=%0d exp=0", name, ov); end
    checks++; if (hi !== eh) begin failures++; $display("FAIL %s hi got=%h exp=%h (op=%0d rs=%h rt=%h)", name, hi, eh, o, a, b); end
    checks++; if (lo !== el) begin failures++; $display("FAIL %s lo got=%h exp=%h (op=%0d rs=%h rt=%h)", name, lo, el, o, a, b); end
    sel = 1'b1; #1;
    checks++; if (dout !== eh) begin failures++; $display("FAIL %s data_out_hi got=%h exp=%h", name, dout, eh); end
    sel = 1'b0; #1;
    checks++; if (dout !== el) begin failures++; $display("FAIL %s data_out_lo got=%h exp=%h", name, dout, el); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset busy_done got=%b exp=00", {busy, done}); end
    checks++; if (hi !== 0 || lo !== 0) begin failures++; $display("FAIL reset hilo got=%h/%h exp=0/0", hi, lo); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    check_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check_op("mult_neg", 2'd0, -32'sd3, 32'd7, 1'b0);
    check_op("div_neg", 2'd2, -32'sd7, 32'd2, 1'b0);
    check_op("divu_zero", 2'd3, 32'd100, 32'd0, 1'b0);
    check_op("div_zero_neg", 2'd2, -32'sd100, 32'd0, 1'b0);
    check_op("div_wrap", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_op("divu_noise", 2'd3, 32'd200, 32'd7, 1'b1);
  endtask

  task automatic test_moves;
    @(negedge clk); rs = 32'd50; mthi = 1'b1;
    @(negedge clk); mthi = 1'b0; rs = 32'd100; mtlo = 1'b1;
    @(negedge clk); mtlo = 1'b0; sel = 1'b1; #1;
    checks++; if (dout !== 32'd50) begin failures++; $display("FAIL mthi data_out got=%h exp=%h", dout, 32'd50); end
    sel = 1'b0; #1;
    checks++; if (dout !== 32'd100) begin failures++; $display("FAIL mtlo data_out got=%h exp=%h", dout, 32'd100); end
    rs = 32'd77; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== 32'd77 || lo !== 32'd77) begin failures++; $display("FAIL mt_both got=%h/%h exp=4d/4d", hi, lo); end
  endtask

  task automatic test_start_wins;
    @(negedge clk); rs = 32'd3; rt = 32'd5; op = 2'd1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk); start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== 32'd77 || lo !== 32'd77) begin failures++; $display("FAIL start_wins hilo got=%h/%h exp=4d/4d", hi, lo); end
    repeat (40) @(negedge clk);
    checks++; if (hi !== 32'd0 || lo !== 32'd15) begin failures++; $display("FAIL start_wins result got=%h/%h exp=0/f", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int dc = 0;
    @(negedge clk); rs = 32'hDEAD; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; rs = 32'd1234; rt = 32'd5678; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy got=%b exp=0", busy); end
    checks++; if (hi !== 0 || lo !== 0) begin failures++; $display("FAIL rst_mid hilo got=%h/%h exp=0/0", hi, lo); end
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) dc++; end
    checks++; if (dc !== 0) begin failures++; $display("FAIL rst_mid done_pulses got=%0d exp=0", dc); end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [1:0]  o;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      check_op("random", o, a, b, n[0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_moves();
    test_start_wins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
